// File: rtl/seven_seg_fsm_if.sv
// Display bus between the timekeeping counter and the 7-segment driver.
// master supplies tick count and decimal points; slave returns segment/anode pins.
interface seven_seg_fsm_if;
    logic [38:0] count;
    logic [7:0]  decs;
    logic [7:0]  cathode;
    logic [7:0]  anode;

    modport master (output count, output decs, input cathode, input anode);
    modport slave  (input count, input decs, output cathode, output anode);
endinterface

// File: rtl/seven_seg_fsm.sv
// Tick count -> HH MM SS cc converter (shared serial divider) and 8-digit scan driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on digits 7..4.
module seven_seg_fsm #(
    parameter int TICKS_PER_CS = 1_000_000,
    parameter int REFRESH_DIV  = 100_000
) (
    input  logic            clock,
    input  logic            reset_n,
    seven_seg_fsm_if.slave  bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [2:0] {
        ST_CAPTURE,
        ST_D0,
        ST_D1,
        ST_D2,
        ST_D3,
        ST_D4,
        ST_UPDATE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [5:0]        r_iter;
    logic [38:0]       r_quo, r_rem;
    logic [38:0]       w_divisor, w_rem_next, w_quo_next;
    logic [39:0]       w_trial;
    logic              w_ge, w_last;
    logic [6:0]        r_cc, r_ss, r_mm, r_hh;
    logic [7:0][3:0]   r_digit;
    logic [RW-1:0]     r_refresh;
    logic [2:0]        r_idx;
    logic [6:0]        w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= ST_CAPTURE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_divisor   = 39'd1;
        w_last      = (r_iter == 6'd39);
        case (r_state)
            ST_CAPTURE: w_state_nxt = ST_D0;
            ST_D0: begin
                w_divisor = 39'(TICKS_PER_CS);
                if (w_last) w_state_nxt = ST_D1;
            end
            ST_D1: begin
                w_divisor = 39'd100;
                if (w_last) w_state_nxt = ST_D2;
            end
            ST_D2: begin
                w_divisor = 39'd60;
                if (w_last) w_state_nxt = ST_D3;
            end
            ST_D3: begin
                w_divisor = 39'd60;
                if (w_last) w_state_nxt = ST_D4;
            end
            ST_D4: begin
                w_divisor = 39'd100;
                if (w_last) w_state_nxt = ST_UPDATE;
            end
            ST_UPDATE: w_state_nxt = ST_CAPTURE;
            default:   w_state_nxt = ST_CAPTURE;
        endcase
    end

    // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    assign w_trial    = {r_rem, r_quo[38]};
    assign w_ge       = (w_trial >= {1'b0, w_divisor});
    assign w_rem_next = 39'(w_ge ? (w_trial - {1'b0, w_divisor}) : w_trial);
    assign w_quo_next = {r_quo[37:0], w_ge};

    // Each quotient stays in r_quo and becomes the next stage's dividend.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_iter  <= '0;
            r_cc    <= '0;
            r_ss    <= '0;
            r_mm    <= '0;
            r_hh    <= '0;
            r_digit <= '0;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    r_quo  <= bus.count;
                    r_iter <= '0;
                end
                ST_UPDATE: begin
                    r_digit <= {bcd(r_hh), bcd(r_mm), bcd(r_ss), bcd(r_cc)};
                    r_iter  <= '0;
                end
                default: begin
                    if (r_iter == 6'd0) begin
                        r_rem <= '0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                    end
                    r_iter <= w_last ? 6'd0 : r_iter + 6'd1;
                    if (w_last) begin
                        case (r_state)
                            ST_D1:   r_cc <= 7'(w_rem_next);
                            ST_D2:   r_ss <= 7'(w_rem_next);
                            ST_D3:   r_mm <= 7'(w_rem_next);
                            ST_D4:   r_hh <= 7'(w_rem_next);
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] w_blank;

    always_comb begin
        w_blank    = '0;
        w_blank[3] = (r_digit[7] == 4'd0);
        w_blank[2] = w_blank[3] && (r_digit[6] == 4'd0);
        w_blank[1] = w_blank[2] && (r_digit[5] == 4'd0);
        w_blank[0] = w_blank[1] && (r_digit[4] == 4'd0);
        w_seg      = seg7(r_digit[r_idx]);
        if (r_idx[2] && w_blank[r_idx[1:0]]) w_seg = 7'h7F;
    end
`else
    always_comb begin
        w_seg = seg7(r_digit[r_idx]);
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_refresh   <= '0;
            r_idx       <= '0;
            bus.anode   <= 8'hFF;
            bus.cathode <= 8'hFF;
        end else begin
            bus.anode   <= ~(8'd1 << r_idx);
            bus.cathode <= {~bus.decs[r_idx], w_seg};
            if (r_refresh == RW'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 3'd1;
            end else begin
                r_refresh <= r_refresh + RW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_fsm.sv
// Randomized self-checking bench for seven_seg_fsm against a time-of-day reference model.
module tb_seven_seg_fsm;
    localparam int TPC = 1;
    localparam int RDIV = 4;

    logic clock = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_edge  = 0;

    logic [3:0] m_dig [8];
    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seven_seg_fsm_if bus ();

    seven_seg_fsm #(.TICKS_PER_CS(TPC), .REFRESH_DIV(RDIV)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    // Edge counter restarts on every edge where reset is held, so it tracks scan phase.
    task automatic tick();
        logic rs;
        rs = reset_n;
        @(posedge clock);
        #1;
        if (rs) n_edge++;
        else    n_edge = 0;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model(input longint unsigned c);
        longint unsigned cs, s, m, h;
        int cc, ss, mm, hh;
        cs = c / TPC;
        cc = int'(cs % 100);
        s  = cs / 100;
        ss = int'(s % 60);
        m  = s / 60;
        mm = int'(m % 60);
        h  = m / 60;
        hh = int'(h % 100);
        m_dig[0] = 4'(cc % 10); m_dig[1] = 4'(cc / 10);
        m_dig[2] = 4'(ss % 10); m_dig[3] = 4'(ss / 10);
        m_dig[4] = 4'(mm % 10); m_dig[5] = 4'(mm / 10);
        m_dig[6] = 4'(hh % 10); m_dig[7] = 4'(hh / 10);
    endtask

    function automatic logic [7:0] exp_cath(input int idx, input logic [7:0] d);
        logic [7:0] code;
        code = segtab[m_dig[idx]];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx >= 4) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int j = idx; j < 8; j++) if (m_dig[j] != 4'd0) all_zero = 1'b0;
            if (all_zero) code = 8'hFF;
        end
`endif
        code[7] = ~d[idx];
        return code;
    endfunction

    // mode 0: decs random each cycle; mode 1: decs held at fixed value
    task automatic check_window(input string tag, input int n, input bit fixed, input logic [7:0] fdecs);
        logic [7:0] d, an;
        int idx;
        for (int i = 0; i < n; i++) begin
            d = fixed ? fdecs : 8'($urandom);
            bus.decs = d;
            tick();
            idx = ((n_edge - 1) / RDIV) % 8;
            an  = ~(8'd1 << idx);
            chk({tag, "_an"}, bus.anode, an);
            chk({tag, "_ca"}, bus.cathode, exp_cath(idx, d));
        end
    endtask

    task automatic run_count(input string tag, input longint unsigned c);
        bus.count = 39'(c);
        wait_edges(420);
        model(c);
        check_window(tag, 36, 1'b0, 8'h00);
    endtask

    initial begin
        longint unsigned rc;
        reset_n   = 1'b0;
        bus.count = '0;
        bus.decs  = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_an", bus.anode, 8'hFF);
            chk("rst_ca", bus.cathode, 8'hFF);
        end
        reset_n = 1'b1;
        tick();
        chk("rel_an", bus.anode, 8'hFE);

        model(0);
        check_window("scan", 36, 1'b1, 8'h00);
        check_window("dp", 32, 1'b1, 8'b0010_1000);

        run_count("c5999", 64'd5999);
        run_count("c6000", 64'd6000);
        run_count("c360000", 64'd360000);
        run_count("cmax", (64'd1 << 39) - 64'd1);

        // Reset in the middle of a conversion: digits stay zero until a full pass completes
        bus.count = 39'd6000;
        bus.decs  = 8'h00;
        reset_n   = 1'b0;
        tick();
        tick();
        chk("mid_rst_an", bus.anode, 8'hFF);
        reset_n = 1'b1;
        wait_edges(100);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_an2", bus.anode, 8'hFF);
        chk("mid_rst_ca2", bus.cathode, 8'hFF);
        reset_n = 1'b1;
        model(0);
        check_window("mid_old", 202, 1'b1, 8'h00);
        model(6000);
        check_window("mid_new", 40, 1'b1, 8'h00);

        for (int i = 0; i < 12; i++) begin
            rc = {32'($urandom), 32'($urandom)};
            case (i % 3)
                0:       rc = rc % 64'd400000;
                1:       rc = rc & ((64'd1 << 26) - 64'd1);
                default: rc = rc & ((64'd1 << 39) - 64'd1);
            endcase
            run_count($sformatf("rnd%0d", i), rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
